// File: rtl/mult_arbiter_pkg.sv
// Shared constants and types for the four-requester arbitrated multiplier.
// Used by the arbiter top and by anything that needs the tag or count widths.
package mult_arbiter_pkg;

    localparam int N_REQ        = 4;
    localparam int MULT_ARB_LAT = 2;
    localparam int TAG_W        = 2;
    localparam int CNT_W        = 16;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED       = 1'b1
    } arb_mode_e;

    function automatic logic [N_REQ-1:0] tag_to_onehot(input tag_t tag);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[tag] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the arbitrated multiplier: packed operands,
// one-hot grant, and the one-hot result strobe with its product.
interface mult_arbiter_if #(
    parameter int a_bits = 16,
    parameter int b_bits = 8,
    parameter int p_bits = 26,
    parameter int n_req  = 4
);
    logic [n_req-1:0]        req_valid;
    logic [n_req*a_bits-1:0] req_a;
    logic [n_req*b_bits-1:0] req_b;
    logic [n_req-1:0]        req_ready;
    logic [n_req-1:0]        res_valid;
    logic signed [p_bits-1:0] res_p;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_p
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_p
    );
endinterface

// File: rtl/mult_arbiter_mult.sv
// Registered signed multiplier: loads a*b when enabled, otherwise holds.
// The product is sign-extended or truncated to the low p_bits.
module mult #(
    parameter int a_bits = 16,
    parameter int b_bits = 8,
    parameter int p_bits = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [a_bits-1:0] a,
    input  logic signed [b_bits-1:0] b,
    output logic signed [p_bits-1:0] p
);

    logic signed [a_bits+b_bits-1:0] full;

    assign full = a * b;

    // The size cast keeps the signed context, so it extends or truncates as needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= p_bits'(full);
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Four-way arbiter in front of one shared two-stage signed multiplier.
// Grants are combinational; results return one-hot tagged two cycles later.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int a_bits = 16,
    parameter int b_bits = 8,
    parameter int p_bits = 26,
    parameter int n_req  = N_REQ
) (
    input  logic              clk,
    input  logic              rst,
    mult_arbiter_if.slave     bus,
    input  logic              pause,
    input  logic              fixed_prio,
    output logic              idle,
    output logic [CNT_W-1:0]  issue_cnt
);

    arb_mode_e                mode;
    tag_t                     rr_ptr;
    tag_t                     grant_idx;
    tag_t                     idx;
    logic                     found;
    logic [n_req-1:0]         grant;
    logic                     s1_valid;
    logic signed [a_bits-1:0] s1_a;
    logic signed [b_bits-1:0] s1_b;
    tag_t                     s1_tag;
    logic                     s2_valid;
    tag_t                     s2_tag;

    assign mode = arb_mode_e'(fixed_prio);

    // Search from rr_ptr (or from 0 in fixed mode); 2-bit index wraps 3->0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        grant     = '0;
        if (!rst && !pause) begin
            for (int k = 0; k < n_req; k++) begin
                idx = (mode == ARB_FIXED) ? tag_t'(k) : rr_ptr + tag_t'(k);
                if (!found && bus.req_valid[idx]) begin
                    found     = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (found) begin
            grant = tag_to_onehot(grant_idx);
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            issue_cnt <= '0;
        end else if (found) begin
            if (mode == ARB_ROUND_ROBIN) begin
                rr_ptr <= grant_idx + tag_t'(1);
            end
            if (issue_cnt != '1) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_tag   <= '0;
        end else begin
            s1_valid <= found;
            if (found) begin
                s1_a   <= bus.req_a[int'(grant_idx)*a_bits +: a_bits];
                s1_b   <= bus.req_b[int'(grant_idx)*b_bits +: b_bits];
                s1_tag <= grant_idx;
            end
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
        end
    end

    // Stage 2 lives in the multiplier; it only loads when stage 1 holds work.
    mult #(
        .a_bits(a_bits),
        .b_bits(b_bits),
        .p_bits(p_bits)
    ) u_mult (
        .clk(clk),
        .rst(rst),
        .en (s1_valid),
        .a  (s1_a),
        .b  (s1_b),
        .p  (bus.res_p)
    );

    assign bus.res_valid = s2_valid ? tag_to_onehot(s2_tag) : '0;
    assign idle          = (grant == '0) & ~s1_valid & ~s2_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized scoreboard bench for mult_arbiter: a spec-level model predicts
// grants and products, and a separate monitor matches tagged results.
module tb_mult_arbiter;
    import mult_arbiter_pkg::*;

    localparam int A_BITS = 16;
    localparam int B_BITS = 8;
    localparam int P_BITS = 26;

    typedef struct {
        logic [3:0]        oh;
        logic [P_BITS-1:0] p;
        int                due;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             pause;
    logic             fixed_prio;
    logic             idle;
    logic [CNT_W-1:0] issue_cnt;

    mult_arbiter_if #(.a_bits(A_BITS), .b_bits(B_BITS), .p_bits(P_BITS), .n_req(N_REQ)) bus ();

    mult_arbiter #(.a_bits(A_BITS), .b_bits(B_BITS), .p_bits(P_BITS), .n_req(N_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pause     (pause),
        .fixed_prio(fixed_prio),
        .idle      (idle),
        .issue_cnt (issue_cnt)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   a_in[4];
    int   b_in[4];
    int   rr_model;
    int   cnt_model;
    bit   hs_d1;
    bit   hs_d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Grant rule: lowest valid index in fixed mode, else first valid from rr.
    function automatic logic [3:0] modelGrant(input logic [3:0] v, input logic p,
                                              input logic fp, input int rr);
        if (p) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int i = fp ? k : (rr + k) % 4;
            if (v[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    task automatic modelReset();
        sb.delete();
        rr_model  = 0;
        cnt_model = 0;
        hs_d1     = 1'b0;
        hs_d2     = 1'b0;
    endtask

    task automatic checkOutput();
        logic [3:0] g;
        longint     prod;
        exp_t       e;
        int         gi;
        g = modelGrant(bus.req_valid, pause, fixed_prio, rr_model);
        compare("req_ready", 64'(bus.req_ready), 64'(g));
        compare("idle", 64'(idle), 64'((g == 4'b0) && !hs_d1 && !hs_d2));
        compare("issue_cnt", 64'(issue_cnt), 64'(cnt_model));
        hs_d2 = hs_d1;
        hs_d1 = (g != 4'b0);
        if (g != 4'b0) begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (g[i]) gi = i;
            prod  = longint'(a_in[gi]) * longint'(b_in[gi]);
            e.oh  = g;
            e.p   = prod[P_BITS-1:0];
            e.due = cyc + MULT_ARB_LAT;
            sb.push_back(e);
            if (!fixed_prio) rr_model = (gi + 1) % 4;
            if (cnt_model < 65535) cnt_model++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic p, input logic fp);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        pause         = p;
        fixed_prio    = fp;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*A_BITS +: A_BITS] = A_BITS'(a_in[i]);
            bus.req_b[i*B_BITS +: B_BITS] = B_BITS'(b_in[i]);
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = '0;
        pause         = 1'b0;
        fixed_prio    = 1'b0;
        modelReset();
        @(negedge clk);
        compare("rst_req_ready", 64'(bus.req_ready), 64'(0));
        compare("rst_res_valid", 64'(bus.res_valid), 64'(0));
        compare("rst_res_p", 64'($unsigned(bus.res_p)), 64'(0));
        compare("rst_issue_cnt", 64'(issue_cnt), 64'(0));
        compare("rst_idle", 64'(idle), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic randOperands();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = int'($urandom_range(0, 65535)) - 32768;
            b_in[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Monitor: every strobe must match the oldest expectation, on its due cycle.
    initial begin
        logic [P_BITS-1:0] last_p;
        exp_t e;
        last_p = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_p = '0;
            end else if (bus.res_valid != '0) begin
                if (sb.size() == 0) begin
                    compare("res_unexpected", 64'(bus.res_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    compare("res_valid", 64'(bus.res_valid), 64'(e.oh));
                    compare("res_p", 64'($unsigned(bus.res_p)), 64'(e.p));
                    compare("res_cycle", 64'(cyc), 64'(e.due));
                    last_p = e.p;
                end
            end else begin
                compare("res_p_hold", 64'($unsigned(bus.res_p)), 64'(last_p));
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    compare("res_missing", 64'(bus.res_valid), 64'(e.oh));
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        pause         = 1'b0;
        fixed_prio    = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < 4; i++) begin
            a_in[i] = 0;
            b_in[i] = 0;
        end
        modelReset();
        doReset();

        $display("[TB] single request");
        a_in[1] = -300;
        b_in[1] = 7;
        applyStimulus(4'b0010, 1'b0, 1'b0);
        compare("single_grant", 64'(bus.req_ready), 64'(4'b0010));
        repeat (4) applyStimulus(4'b0000, 1'b0, 1'b0);

        $display("[TB] round-robin from reset");
        doReset();
        for (int k = 0; k < 8; k++) begin
            randOperands();
            applyStimulus(4'b1111, 1'b0, 1'b0);
            compare("rr_order", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
        end

        $display("[TB] fixed priority");
        for (int k = 0; k < 3; k++) begin
            randOperands();
            applyStimulus(4'b1111, 1'b0, 1'b1);
            compare("fixed_grant", 64'(bus.req_ready), 64'(4'b0001));
        end
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);

        $display("[TB] operand extremes");
        a_in[0] = -32768;
        b_in[0] = -128;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        a_in[0] = 32767;
        b_in[0] = 127;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);

        $display("[TB] pause mid-stream");
        randOperands();
        applyStimulus(4'b1111, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            compare("paused_grant", 64'(bus.req_ready), 64'(0));
        end
        applyStimulus(4'b1111, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);

        $display("[TB] reset mid-flight");
        randOperands();
        applyStimulus(4'b1110, 1'b0, 1'b0);
        doReset();
        applyStimulus(4'b1111, 1'b0, 1'b0);
        compare("post_rst_grant", 64'(bus.req_ready), 64'(4'b0001));
        repeat (4) applyStimulus(4'b0000, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            randOperands();
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0));
        end
        repeat (5) applyStimulus(4'b0000, 1'b0, 1'b0);
        compare("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
